// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types for the instruction-memory loader.
//   state_t   - loader FSM states
//   ERR_*     - err_code values reported on the err_code port
//   is_rx()   - true in the states that take stream bytes
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic is_rx(input state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHK};
    endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// loader_timeout_counter: idle-cycle counter for the loader.
//   clock, reset : clock, async active-low reset
//   clr          : force the count to 0 (has priority over en)
//   en           : count one cycle
//   tc           : count has reached TIMEOUT_CYC-1
module loader_timeout_counter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Saturate at terminal count so the flag cannot wrap away.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !tc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Frame: LEN_HI, LEN_LO, N words (high byte first), CHK; all bytes sum to 0.
//   clock, reset          : clock, async active-low reset
//   start                 : begin a load (ignored while busy)
//   in_data/valid/ready   : byte stream handshake
//   imem_we/addr/wdata    : instruction-memory write port (one-cycle strobe)
//   cpu_hold              : CPU reset, released only after a good load
//   busy, done, err_code  : load status; done/err_code sticky until start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [15:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code
);

    state_t        state_q, state_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [1:0]    err_q, err_d;

    logic          rx, accept, tmo, last_word;
    logic [15:0]   len_rx;

    assign rx        = is_rx(state_q);
    assign accept    = in_valid && rx;
    assign len_rx    = {len_hi_q, in_data};
    assign last_word = (16'(idx_q) + 16'd1) == len_q;

    // Timer runs only while receiving; any accept or leaving the receive
    // states restarts it.
    loader_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clock (clock),
        .reset (reset),
        .clr   (accept || !rx),
        .en    (rx),
        .tc    (tmo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        hi_d     = hi_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        err_d    = err_q;

        if (accept)
            sum_d = sum_q + in_data;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    err_d   = ERR_NONE;
                    sum_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_rx;
                    if (32'(len_rx) > DEPTH) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                    end else if (len_rx == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    addr_d  = idx_q;
                    wdata_d = {hi_q, in_data};
                    we_d    = 1'b1;
                    // Index stops at the last word so it never wraps.
                    if (last_word) begin
                        state_d = ST_CHK;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (sum_d == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CHK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accept in the terminal-count cycle takes precedence.
        if (rx && !accept && tmo) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_comb begin
        in_ready   = rx;
        busy       = rx;
        done       = (state_q == ST_DONE);
        cpu_hold   = (state_q != ST_DONE);
        imem_we    = we_q;
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        err_code   = err_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int TMO   = 1024;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_hold, busy, done;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    // expected writes: {addr, data}
    logic [AW+15:0] exp_wr[$];

    imem_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
        .clock(clock), .reset(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (imem_we) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
            end else begin
                logic [AW+15:0] e;
                e = exp_wr.pop_front();
                chk("write_addr", int'(imem_addr), int'(e[AW+15:16]));
                chk("write_data", int'(imem_wdata), int'(e[15:0]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles; returns at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        taken    = 1'b0;
        for (int t = 0; t < 64 && !taken; t++) begin
            if (in_ready) taken = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!taken) chk("byte_accept_timeout", 0, 1);
    endtask

    function automatic int pick_gap(input int maxgap);
        if (maxgap == 0 || $urandom_range(3) != 0) return 0;
        return int'($urandom_range(maxgap));
    endfunction

    task automatic check_status(input bit exp_done, input int exp_err);
        chk("done", int'(done), int'(exp_done));
        chk("err_code", int'(err_code), exp_err);
        chk("cpu_hold", int'(cpu_hold), int'(!exp_done));
        chk("busy", int'(busy), 0);
        chk("in_ready", int'(in_ready), 0);
    endtask

    // Reference model: frame bytes from the word list, checksum chosen so the
    // whole frame sums to zero (plus 'bad' to corrupt it), expected writes are
    // simply word i at address i.
    task automatic send_words(input logic [15:0] ws[$], input bit bad, input int maxgap);
        logic [7:0] bytes[$];
        logic [7:0] s, c;
        int n;
        n = ws.size();
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        foreach (ws[i]) begin
            bytes.push_back(ws[i][15:8]);
            bytes.push_back(ws[i][7:0]);
            exp_wr.push_back({AW'(i), ws[i]});
        end
        s = 8'h00;
        foreach (bytes[i]) s = s + bytes[i];
        c = 8'(0 - int'(s)) + (bad ? 8'd1 : 8'd0);
        bytes.push_back(c);
        pulse_start();
        foreach (bytes[i]) send_byte(bytes[i], pick_gap(maxgap));
        check_status(8'(s + c) == 8'h00, (8'(s + c) == 8'h00) ? 0 : 2);
        @(negedge clock);
        chk("writes_drained", exp_wr.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got stall expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ws[$];
        logic [7:0]  c;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_imem_we", int'(imem_we), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_code), 0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("idle_in_ready", int'(in_ready), 0);

        // 1: two-word good frame, back to back
        ws = '{16'h1234, 16'hABCD};
        send_words(ws, 1'b0, 0);
        // 2: same frame, corrupted checksum (writes still happen)
        send_words(ws, 1'b1, 0);

        // Bytes offered while not ready are not consumed
        in_data = 8'h5A; in_valid = 1'b1;
        repeat (4) @(negedge clock);
        chk("err_holds_ready_low", int'(in_ready), 0);
        chk("err_sticky", int'(err_code), 2);
        in_valid = 1'b0;

        // 3: length over DEPTH
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        chk("hold_after_start", int'(cpu_hold), 1);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_status(1'b0, 1);
        repeat (4) @(negedge clock);

        // 4: timeout after partial word, exact boundary
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        repeat (TMO - 1) @(negedge clock);
        chk("tmo_not_yet_busy", int'(busy), 1);
        chk("tmo_not_yet_err", int'(err_code), 0);
        @(negedge clock);
        check_status(1'b0, 3);

        // Restart; an accept exactly at terminal count must win
        exp_wr.push_back({AW'(0), 16'hBEEF});
        c = 8'(0 - (1 + 'hBE + 'hEF));
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, TMO - 1);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        send_byte(c, 0);
        check_status(1'b1, 0);

        // 5: empty frame
        ws = {};
        send_words(ws, 1'b0, 0);
        // case 1 with random gaps
        ws = '{16'h1234, 16'hABCD};
        send_words(ws, 1'b0, 200);

        // N == DEPTH
        ws = {};
        for (int i = 0; i < DEPTH; i++) ws.push_back(16'($urandom));
        send_words(ws, 1'b0, 0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            ws = {};
            for (int i = 0; i < int'($urandom_range(8)); i++) ws.push_back(16'($urandom));
            send_words(ws, $urandom_range(3) == 0, 20);
        end

        // 6: reset mid-DATA_LO
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_we", int'(imem_we), 0);
        chk("mid_rst_addr", int'(imem_addr), 0);
        chk("mid_rst_wdata", int'(imem_wdata), 0);
        chk("mid_rst_hold", int'(cpu_hold), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err_code), 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // start during busy is ignored
        exp_wr.push_back({AW'(0), 16'h1234});
        c = 8'(0 - (1 + 'h12 + 'h34));
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        pulse_start();
        send_byte(8'h12, 0);
        pulse_start();
        send_byte(8'h34, 0);
        send_byte(c, 0);
        check_status(1'b1, 0);

        repeat (3) @(negedge clock);
        chk("final_writes_drained", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
